// File: rtl/alu_pkg.sv
// Shared constants for the ALU board interface: bus widths, opcode values,
// push-button indices and the debounce FSM state encoding.
package alu_pkg;

    localparam int NB_DATA      = 8;
    localparam int NB_OPCODE    = 6;
    localparam int N_PULSADORES = 3;

    localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OPCODE-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OPCODE-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OPCODE-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OPCODE-1:0] OP_NOR = 6'b100111;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } btn_state_e;

    // The debounced level stays high from the accepted press until the
    // release has been confirmed.
    function automatic logic is_level_high(input btn_state_e state);
        return (state == ST_PRESSED) || (state == ST_WAIT_RELEASE);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchroniser, debounce FSM and stability counter.
// Emits a single-cycle qualify flag on an accepted press and a debounced level.
//
//  state           | meaning
//  ----------------+-------------------------------------------------------
//  ST_IDLE         | button released and stable, counter cleared
//  ST_WAIT_PRESS   | synced input high, counting consecutive high samples
//  ST_PRESSED      | press accepted, debounced level high
//  ST_WAIT_RELEASE | synced input low, counting consecutive low samples
//
// The qualify flag is decoded from the terminal count so that the top-level
// output register strobes on the same edge the FSM moves to ST_PRESSED.
module button_debouncer
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNTER      = 20
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_qualify,
    output logic o_pressed
);

    localparam logic [NB_COUNTER-1:0] CNT_TERMINAL = NB_COUNTER'(DEBOUNCE_CYCLES);
    localparam logic [NB_COUNTER-1:0] CNT_ONE      = NB_COUNTER'(1);
    localparam logic [NB_COUNTER-1:0] CNT_MAX      = '1;

    logic                  sync_meta;
    logic                  sync_q;
    btn_state_e            state;
    btn_state_e            state_next;
    logic [NB_COUNTER-1:0] count;
    logic [NB_COUNTER-1:0] count_next;

    // Two-flop synchroniser for the raw, asynchronous button pin.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= i_button;
            sync_q    <= sync_meta;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state, counter update and qualify decode.
    always_comb begin
        state_next = state;
        count_next = count;
        o_qualify  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync_q) begin
                    state_next = ST_WAIT_PRESS;
                    count_next = CNT_ONE;
                end
            end
            ST_WAIT_PRESS: begin
                if (count == CNT_TERMINAL) begin
                    state_next = ST_PRESSED;
                    count_next = '0;
                    o_qualify  = 1'b1;
                end else if (sync_q) begin
                    count_next = (count == CNT_MAX) ? count : count + CNT_ONE;
                end else begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end
            end
            ST_PRESSED: begin
                if (!sync_q) begin
                    state_next = ST_WAIT_RELEASE;
                    count_next = CNT_ONE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (count == CNT_TERMINAL) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (!sync_q) begin
                    count_next = (count == CNT_MAX) ? count : count + CNT_ONE;
                end else begin
                    state_next = ST_PRESSED;
                    count_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    assign o_pressed = is_level_high(state);

endmodule

// File: rtl/input_conditioner.sv
// Board-side front end for the ALU controller: synchronises the slide
// switches, debounces every push-button and issues one-hot single-cycle load
// strobes together with a switch snapshot taken on the same edge.
module input_conditioner #(
    parameter int NB_DATA         = alu_pkg::NB_DATA,
    parameter int N_PULSADORES    = alu_pkg::N_PULSADORES,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNTER      = 20
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_DATA-1:0]      i_switches,
    input  logic [N_PULSADORES-1:0] i_pulsadores,
    output logic [NB_DATA-1:0]      o_switches,
    output logic [N_PULSADORES-1:0] o_pulsadores,
    output logic [N_PULSADORES-1:0] o_pressed
);

    logic [NB_DATA-1:0]      sw_meta;
    logic [NB_DATA-1:0]      sw_sync;
    logic [N_PULSADORES-1:0] qualify;
    logic [N_PULSADORES-1:0] pressed;
    logic [N_PULSADORES-1:0] strobe_sel;

    // Two-flop synchroniser for the slide switches.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= i_switches;
            sw_sync <= sw_meta;
        end
    end

    for (genvar g = 0; g < N_PULSADORES; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .NB_COUNTER      (NB_COUNTER)
        ) u_debouncer (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_button  (i_pulsadores[g]),
            .o_qualify (qualify[g]),
            .o_pressed (pressed[g])
        );
    end

    // Priority select: the lowest-index qualify wins, the rest are dropped.
    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        strobe_sel = '0;
        for (int i = N_PULSADORES - 1; i >= 0; i--) begin
            if (qualify[i]) begin
                strobe_sel    = '0;
                strobe_sel[i] = 1'b1;
            end
        end
    end

    // Strobe register and switch snapshot, loaded on the same edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_pulsadores <= '0;
            o_switches   <= '0;
        end else begin
            o_pulsadores <= strobe_sel;
            if (|qualify) begin
                o_switches <= sw_sync;
            end
        end
    end

    assign o_pressed = pressed;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with a short debounce window.
module tb_input_conditioner;

    localparam int DB  = 4;
    localparam int NBC = 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [2:0] btn;
    logic [7:0] o_switches;
    logic [2:0] o_pulsadores;
    logic [2:0] o_pressed;

    int vectors     = 0;
    int miscompares = 0;

    input_conditioner #(
        .NB_DATA         (8),
        .N_PULSADORES    (3),
        .DEBOUNCE_CYCLES (DB),
        .NB_COUNTER      (NBC)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_switches   (sw),
        .i_pulsadores (btn),
        .o_switches   (o_switches),
        .o_pulsadores (o_pulsadores),
        .o_pressed    (o_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each button has a debounced level and a run length of
    // consecutive synced samples that disagree with it. Once the run reaches
    // DB, the next edge flips the level; a flip to 1 is a press.
    int         run [3];
    bit         lvl [3];
    logic [2:0] d1, d2;
    logic [7:0] sd1, sd2;
    logic [2:0] m_pulse;
    logic [7:0] m_sw;
    logic [2:0] m_pressed;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            lvl[i] = 1'b0;
        end
        d1 = '0; d2 = '0; sd1 = '0; sd2 = '0;
        m_pulse = '0; m_sw = '0; m_pressed = '0;
    endtask

    task automatic model_edge();
        logic [2:0] newly;
        if (!rst_n) begin
            model_clear();
            return;
        end
        newly = '0;
        for (int i = 0; i < 3; i++) begin
            if (run[i] == DB) begin
                lvl[i] = !lvl[i];
                run[i] = 0;
                if (lvl[i]) newly[i] = 1'b1;
            end else if (d2[i] != lvl[i]) begin
                run[i] = run[i] + 1;
            end else begin
                run[i] = 0;
            end
        end
        m_pulse = '0;
        for (int i = 0; i < 3; i++) begin
            if (newly[i] && m_pulse == 3'b000) m_pulse[i] = 1'b1;
        end
        if (newly != 3'b000) m_sw = sd2;
        for (int i = 0; i < 3; i++) m_pressed[i] = lvl[i];
        d2 = d1; d1 = btn;
        sd2 = sd1; sd1 = sw;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", {2'b00, o_pulsadores, o_switches, o_pressed},
              {2'b00, m_pulse, m_sw, m_pressed});
    endtask

    task automatic watch(input int n, input logic [2:0] pat,
                         output int hits, output int first_at, output int others);
        hits = 0; first_at = -1; others = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (o_pulsadores == pat) begin
                hits++;
                if (first_at < 0) first_at = k;
            end else if (o_pulsadores != 3'b000) begin
                others++;
            end
        end
    endtask

    task automatic release_idle();
        btn = 3'b000;
        repeat (12) step();
    endtask

    typedef struct {
        logic [2:0] btn;
        logic [7:0] sw;
        int         cycles;
        logic [2:0] e_pulse;
        logic [7:0] e_sw;
        logic [2:0] e_pressed;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int hits, first_at, others, total;
        int hold [3];

        model_clear();
        rst_n = 1'b0;
        btn   = 3'b000;
        sw    = 8'h00;

        // Reset held with random pins: everything stays at zero.
        for (int c = 0; c < 10; c++) begin
            #1;
            btn = 3'($urandom_range(0, 7));
            sw  = 8'($urandom);
            step();
            check("reset_out", {2'b00, o_pulsadores, o_switches, o_pressed}, 16'h0000);
        end
        rst_n = 1'b1;
        btn   = 3'b000;
        for (int c = 0; c < 10; c++) begin
            sw = 8'($urandom);
            step();
            check("idle_out", {2'b00, o_pulsadores, o_switches, o_pressed}, 16'h0000);
        end

        // Button 0 held 20 cycles with switches A5, then released.
        tbl = '{
            '{3'b001, 8'hA5,  6, 3'b000, 8'h00, 3'b000},
            '{3'b001, 8'hA5,  1, 3'b001, 8'hA5, 3'b001},
            '{3'b001, 8'hA5, 13, 3'b000, 8'hA5, 3'b001},
            '{3'b000, 8'hA5,  6, 3'b000, 8'hA5, 3'b001},
            '{3'b000, 8'hA5,  4, 3'b000, 8'hA5, 3'b000}
        };
        foreach (tbl[r]) begin
            btn = tbl[r].btn;
            sw  = tbl[r].sw;
            for (int k = 0; k < tbl[r].cycles; k++) begin
                step();
                check($sformatf("tbl%0d", r),
                      {2'b00, o_pulsadores, o_switches, o_pressed},
                      {2'b00, tbl[r].e_pulse, tbl[r].e_sw, tbl[r].e_pressed});
            end
        end

        // Bounce button 1, then hold it.
        total = 0;
        for (int p = 0; p < 4; p++) begin
            btn = (p % 2 == 0) ? 3'b010 : 3'b000;
            watch(2, 3'b010, hits, first_at, others);
            total += hits + others;
        end
        check("bounce_quiet", 16'(total), 16'd0);
        btn = 3'b010;
        watch(20, 3'b010, hits, first_at, others);
        check("bounce_hits", 16'(hits), 16'd1);
        check("bounce_lat", 16'(first_at), 16'd7);
        release_idle();

        // Buttons 0 and 2 together: only button 0 strobes.
        btn = 3'b101;
        watch(12, 3'b001, hits, first_at, others);
        check("simul_hits", 16'(hits), 16'd1);
        check("simul_lat", 16'(first_at), 16'd7);
        check("simul_other", 16'(others), 16'd0);
        release_idle();
        btn = 3'b100;
        watch(12, 3'b100, hits, first_at, others);
        check("op_hits", 16'(hits), 16'd1);
        check("op_lat", 16'(first_at), 16'd7);
        check("op_other", 16'(others), 16'd0);
        release_idle();

        // Reset in the middle of a count, button held through release.
        btn = 3'b010;
        repeat (4) step();
        rst_n = 1'b0;
        watch(5, 3'b010, hits, first_at, others);
        check("rst_quiet", 16'(hits + others), 16'd0);
        rst_n = 1'b1;
        watch(12, 3'b010, hits, first_at, others);
        check("rst_hits", 16'(hits), 16'd1);
        check("rst_lat", 16'(first_at), 16'd7);
        release_idle();

        // Switch snapshot holds between strobes.
        sw  = 8'h3C;
        btn = 3'b001;
        watch(10, 3'b001, hits, first_at, others);
        check("snap1_hits", 16'(hits), 16'd1);
        check("snap1_sw", 16'(o_switches), 16'h003C);
        btn = 3'b000;
        repeat (10) step();
        sw = 8'hC3;
        repeat (4) step();
        check("snap_hold", 16'(o_switches), 16'h003C);
        btn = 3'b001;
        repeat (6) step();
        check("snap_pre", {o_switches, 5'b0, o_pulsadores}, 16'h3C00);
        step();
        check("snap_post", {o_switches, 5'b0, o_pulsadores}, 16'hC301);
        release_idle();

        // Random pins against the model, with occasional resets.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 12);
                end
                hold[b]--;
            end
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
